// File: rtl/bridge_rx_if.sv
// bridge_rx_if -- byte input and register-bus request output of the UART
// command decoder, bundled so the decoder and its environment share one
// declaration.
//
// Signals:
//   data_i   [7:0]   received ASCII byte
//   valid_i          data_i is valid this cycle (at most one byte per cycle)
//   addr_o   [15:0]  decoded register address (held until the next request)
//   wdata_o  [15:0]  decoded write data, 0x0000 for reads
//   rw_o             1 = write, 0 = read
//   valid_o          one-cycle request strobe
//   error_o          one-cycle malformed-message pulse
//
// Handshake: valid-only on both sides, with no ready. A byte is consumed in
// every cycle valid_i is high. A request is delivered in every cycle valid_o
// is high. addr_o/wdata_o/rw_o are meaningful whenever valid_o is high.
// Neither side can stall the other.
//
// Modports:
//   slave  -- the decoder (consumes bytes, produces requests)
//   master -- the environment (produces bytes, observes requests)
interface bridge_rx_if;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] wdata_o;
    logic        rw_o;
    logic        valid_o;
    logic        error_o;

    modport slave (
        input  data_i, valid_i,
        output addr_o, wdata_o, rw_o, valid_o, error_o
    );

    modport master (
        output data_i, valid_i,
        input  addr_o, wdata_o, rw_o, valid_o, error_o
    );
endinterface

// File: rtl/bridge_rx.sv
// bridge_rx -- decodes ASCII command messages received from a UART into
// register-bus requests.
//   Read  : 'R' + 4 hex digits (address) + CR/LF
//   Write : 'W' + 4 hex digits (address) + 4 hex digits (data) + CR/LF
//
// A request strobe (valid_o) or an error pulse (error_o) appears one cycle
// after the byte that completes or breaks the message.
//
// Parameters:
//   ACCEPT_LOWERCASE  1: 'a'-'f' are hex digits; 0: they are invalid bytes
//
// Ports:
//   clk      single clock
//   rst_n    asynchronous active-low reset
//   bus      bridge_rx_if.slave (byte input, request output)
//   o_state  current decoder state (0 = IDLE, 1 = READ, 2 = WRITE)
module bridge_rx #(
    parameter bit ACCEPT_LOWERCASE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    bridge_rx_if.slave        bus,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_buf;
    logic [31:0] w_buf_nxt;
    logic        w_done;
    logic        w_err;

    logic        r_valid;
    logic        r_error;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_rw;

    logic        w_is_hex;
    logic [3:0]  w_nib;
    logic        w_is_term;
    logic        w_is_r;
    logic        w_is_w;
    logic [3:0]  w_limit;

    // Byte classification.
    always_comb begin
        w_is_hex = 1'b0;
        w_nib    = 4'd0;
        if (bus.data_i >= 8'h30 && bus.data_i <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nib    = bus.data_i[3:0];
        end else if (bus.data_i >= 8'h41 && bus.data_i <= 8'h46) begin
            // 'A'..'F' have low nibble 1..6, so adding 9 gives 10..15.
            w_is_hex = 1'b1;
            w_nib    = bus.data_i[3:0] + 4'd9;
        end else if (ACCEPT_LOWERCASE && bus.data_i >= 8'h61 && bus.data_i <= 8'h66) begin
            w_is_hex = 1'b1;
            w_nib    = bus.data_i[3:0] + 4'd9;
        end
    end

    assign w_is_term = (bus.data_i == 8'h0D) || (bus.data_i == 8'h0A);
    assign w_is_r    = (bus.data_i == 8'h52);
    assign w_is_w    = (bus.data_i == 8'h57);
    assign w_limit   = (r_state == S_WRITE) ? 4'd8 : 4'd4;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_nxt   = r_buf;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (bus.valid_i) begin
            case (r_state)
                S_IDLE: begin
                    // Anything other than a command letter, including a
                    // trailing LF after CR, is silently dropped here.
                    if (w_is_r || w_is_w) begin
                        w_state_nxt = w_is_r ? S_READ : S_WRITE;
                        w_cnt_nxt   = 4'd0;
                        w_buf_nxt   = 32'd0;
                    end
                end
                S_READ, S_WRITE: begin
                    if (w_is_r || w_is_w) begin
                        // A new command letter aborts the current message
                        // and starts the new one immediately.
                        w_err       = 1'b1;
                        w_state_nxt = w_is_r ? S_READ : S_WRITE;
                        w_cnt_nxt   = 4'd0;
                        w_buf_nxt   = 32'd0;
                    end else if (w_is_hex) begin
                        if (r_cnt < w_limit) begin
                            w_buf_nxt = {r_buf[27:0], w_nib};
                            w_cnt_nxt = r_cnt + 4'd1;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else if (w_is_term) begin
                        if (r_cnt == w_limit) begin
                            w_done = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_buf   <= 32'd0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_addr  <= 16'd0;
            r_wdata <= 16'd0;
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_buf   <= w_buf_nxt;
            r_valid <= w_done;
            r_error <= w_err;
            // The terminator does not shift the buffer, so r_buf holds the
            // complete message digits in the cycle w_done is high.
            if (w_done) begin
                if (r_state == S_WRITE) begin
                    r_addr  <= r_buf[31:16];
                    r_wdata <= r_buf[15:0];
                    r_rw    <= 1'b1;
                end else begin
                    r_addr  <= r_buf[15:0];
                    r_wdata <= 16'd0;
                    r_rw    <= 1'b0;
                end
            end
        end
    end

    assign bus.valid_o = r_valid;
    assign bus.error_o = r_error;
    assign bus.addr_o  = r_addr;
    assign bus.wdata_o = r_wdata;
    assign bus.rw_o    = r_rw;
    assign o_state     = r_state;

endmodule

// File: tb/tb_bridge_rx.sv
module tb_bridge_rx;

    logic clk;
    logic rst_n;
    logic [1:0] state0;
    logic [1:0] state1;

    bridge_rx_if bus0 ();
    bridge_rx_if bus1 ();

    bridge_rx #(.ACCEPT_LOWERCASE(1'b1)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus0.slave),
        .o_state (state0)
    );

    bridge_rx #(.ACCEPT_LOWERCASE(1'b0)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus1.slave),
        .o_state (state1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Message-level view: mode (0 idle, 1 read, 2 write), the list of digits
    // collected so far, and the visible output registers.
    int          m_mode [2];
    int          m_len  [2];
    int          m_nib  [2][8];
    logic        m_v    [2];
    logic        m_e    [2];
    logic [15:0] m_a    [2];
    logic [15:0] m_w    [2];
    logic        m_rw   [2];
    logic [32:0] exp_q0 [$];
    logic [32:0] exp_q1 [$];

    function automatic int hexval(input logic [7:0] c, input bit lc);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (lc && c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_len[k] = 0;
            m_v[k] = 1'b0; m_e[k] = 1'b0;
            m_a[k] = 16'd0; m_w[k] = 16'd0; m_rw[k] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_byte(input int k, input logic [7:0] d, input logic v, input bit lc);
        int hv;
        int need;
        int a;
        int w;
        m_v[k] = 1'b0;
        m_e[k] = 1'b0;
        if (v) begin
            hv   = hexval(d, lc);
            need = (m_mode[k] == 1) ? 4 : 8;
            if (m_mode[k] == 0) begin
                if (d == "R") begin m_mode[k] = 1; m_len[k] = 0; end
                else if (d == "W") begin m_mode[k] = 2; m_len[k] = 0; end
            end else if (d == "R" || d == "W") begin
                m_e[k] = 1'b1;
                m_mode[k] = (d == "R") ? 1 : 2;
                m_len[k] = 0;
            end else if (hv >= 0) begin
                if (m_len[k] < need) begin
                    m_nib[k][m_len[k]] = hv;
                    m_len[k]++;
                end else begin
                    m_e[k] = 1'b1;
                    m_mode[k] = 0;
                end
            end else if (d == 8'h0D || d == 8'h0A) begin
                if (m_len[k] == need) begin
                    a = 0;
                    for (int i = 0; i < 4; i++) a = a * 16 + m_nib[k][i];
                    w = 0;
                    if (m_mode[k] == 2)
                        for (int i = 4; i < 8; i++) w = w * 16 + m_nib[k][i];
                    m_v[k]  = 1'b1;
                    m_a[k]  = a[15:0];
                    m_w[k]  = w[15:0];
                    m_rw[k] = (m_mode[k] == 2);
                    if (k == 0) exp_q0.push_back({m_rw[k], m_a[k], m_w[k]});
                    else        exp_q1.push_back({m_rw[k], m_a[k], m_w[k]});
                end else begin
                    m_e[k] = 1'b1;
                end
                m_mode[k] = 0;
            end else begin
                m_e[k] = 1'b1;
                m_mode[k] = 0;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic v, input logic e,
                             input logic [15:0] a, input logic [15:0] w, input logic rw);
        logic [32:0] q;
        chk($sformatf("dut%0d valid_o", k), {31'd0, v}, {31'd0, m_v[k]});
        chk($sformatf("dut%0d error_o", k), {31'd0, e}, {31'd0, m_e[k]});
        chk($sformatf("dut%0d addr_o", k), {16'd0, a}, {16'd0, m_a[k]});
        chk($sformatf("dut%0d wdata_o", k), {16'd0, w}, {16'd0, m_w[k]});
        chk($sformatf("dut%0d rw_o", k), {31'd0, rw}, {31'd0, m_rw[k]});
        if (v) begin
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                chk($sformatf("dut%0d unexpected request", k), {31'd0, v}, 32'd0);
            end else begin
                q = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("dut%0d request", k), {15'd0, rw, a}, {15'd0, q[32:16]});
                chk($sformatf("dut%0d request data", k), {16'd0, w}, {16'd0, q[15:0]});
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negative edge; returns at the next negative edge with the
    // outputs for this byte already compared against the model.
    task automatic step(input logic [7:0] d, input logic v);
        bus0.data_i = d; bus0.valid_i = v;
        bus1.data_i = d; bus1.valid_i = v;
        model_byte(0, d, v, 1'b1);
        model_byte(1, d, v, 1'b0);
        @(posedge clk);
        #1;
        check_dut(0, bus0.valid_o, bus0.error_o, bus0.addr_o, bus0.wdata_o, bus0.rw_o);
        check_dut(1, bus1.valid_o, bus1.error_o, bus1.addr_o, bus1.wdata_o, bus1.rw_o);
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus0.valid_i = 1'b0; bus1.valid_i = 1'b0;
        #1;
        model_reset();
        chk("rst valid0", {31'd0, bus0.valid_o}, 32'd0);
        chk("rst error0", {31'd0, bus0.error_o}, 32'd0);
        chk("rst addr0", {16'd0, bus0.addr_o}, 32'd0);
        chk("rst wdata0", {16'd0, bus0.wdata_o}, 32'd0);
        chk("rst rw0", {31'd0, bus0.rw_o}, 32'd0);
        chk("rst state0", {30'd0, state0}, 32'd0);
        chk("rst valid1", {31'd0, bus1.valid_o}, 32'd0);
        chk("rst error1", {31'd0, bus1.error_o}, 32'd0);
        chk("rst addr1", {16'd0, bus1.addr_o}, 32'd0);
        chk("rst state1", {30'd0, state1}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        ev;
        logic        ee;
        logic [15:0] ea;
        logic [15:0] ew;
        logic        erw;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] d, input logic v, input logic ev, input logic ee,
                       input logic [15:0] ea, input logic [15:0] ew, input logic erw);
        vec_t t;
        t.d = d; t.v = v; t.ev = ev; t.ee = ee; t.ea = ea; t.ew = ew; t.erw = erw;
        tbl.push_back(t);
    endtask

    // ---------------- test ----------------
    initial begin
        int r;
        string hx;
        logic [7:0] c;
        hx = "0123456789ABCDEFabcdef";

        // Read "R0002" with an idle cycle carrying a stray CR, then CR LF.
        add("R",   1, 0, 0, 16'h0000, 16'h0000, 0);
        add("0",   1, 0, 0, 16'h0000, 16'h0000, 0);
        add("0",   1, 0, 0, 16'h0000, 16'h0000, 0);
        add(8'h0D, 0, 0, 0, 16'h0000, 16'h0000, 0);
        add("0",   1, 0, 0, 16'h0000, 16'h0000, 0);
        add("2",   1, 0, 0, 16'h0000, 16'h0000, 0);
        add(8'h0D, 1, 1, 0, 16'h0002, 16'h0000, 0);
        add(8'h0A, 1, 0, 0, 16'h0002, 16'h0000, 0);
        // Write "W00016789" CR, back to back.
        add("W",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add("0",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add("0",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add("0",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add("1",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add("6",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add("7",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add("8",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add("9",   1, 0, 0, 16'h0002, 16'h0000, 0);
        add(8'h0D, 1, 1, 0, 16'h0001, 16'h6789, 1);
        add("x",   1, 0, 0, 16'h0001, 16'h6789, 1);

        rst_n = 1'b0;
        bus0.data_i = 8'd0; bus0.valid_i = 1'b0;
        bus1.data_i = 8'd0; bus1.valid_i = 1'b0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].d, tbl[i].v);
            chk($sformatf("tbl[%0d] valid", i), {31'd0, bus0.valid_o}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl[%0d] error", i), {31'd0, bus0.error_o}, {31'd0, tbl[i].ee});
            chk($sformatf("tbl[%0d] addr", i), {16'd0, bus0.addr_o}, {16'd0, tbl[i].ea});
            chk($sformatf("tbl[%0d] wdata", i), {16'd0, bus0.wdata_o}, {16'd0, tbl[i].ew});
            chk($sformatf("tbl[%0d] rw", i), {31'd0, bus0.rw_o}, {31'd0, tbl[i].erw});
        end

        // Lowercase digits: accepted by dut0, rejected at 'a' by dut1.
        send_str("W0");
        step("a", 1'b1);
        chk("lc1 error at a", {31'd0, bus1.error_o}, 32'd1);
        chk("lc0 no error at a", {31'd0, bus0.error_o}, 32'd0);
        send_str("0bFfEe");
        step(8'h0A, 1'b1);
        chk("lc0 valid", {31'd0, bus0.valid_o}, 32'd1);
        chk("lc0 addr", {16'd0, bus0.addr_o}, 32'h0A0B);
        chk("lc0 wdata", {16'd0, bus0.wdata_o}, 32'hFFEE);
        chk("lc0 rw", {31'd0, bus0.rw_o}, 32'd1);
        chk("lc1 no valid", {31'd0, bus1.valid_o}, 32'd0);
        step(8'h00, 1'b0);

        // Short read then a good one.
        send_str("R12");
        step(8'h0D, 1'b1);
        chk("short err", {31'd0, bus0.error_o}, 32'd1);
        chk("short no valid", {31'd0, bus0.valid_o}, 32'd0);
        send_str("R0003");
        step(8'h0A, 1'b1);
        chk("read3 valid", {31'd0, bus0.valid_o}, 32'd1);
        chk("read3 addr", {16'd0, bus0.addr_o}, 32'h0003);

        // Abort by a new command letter; next message starts at once,
        // in the same cycle the previous strobe is high.
        send_str("R12");
        step("W", 1'b1);
        chk("abort err", {31'd0, bus0.error_o}, 32'd1);
        send_str("00050001");
        step(8'h0D, 1'b1);
        chk("w5 valid", {31'd0, bus0.valid_o}, 32'd1);
        chk("w5 addr", {16'd0, bus0.addr_o}, 32'h0005);
        chk("w5 wdata", {16'd0, bus0.wdata_o}, 32'h0001);
        step("R", 1'b1);
        send_str("ABCD");
        step(8'h0D, 1'b1);
        chk("rABCD addr", {16'd0, bus0.addr_o}, 32'hABCD);

        // Too many digits on a read.
        send_str("R00001");
        chk("overflow err", {31'd0, bus0.error_o}, 32'd1);

        // Reset mid-message; leftovers ignored afterwards.
        send_str("W0001");
        do_reset();
        send_str("67");
        step(8'h0D, 1'b1);
        chk("post-rst no err", {31'd0, bus0.error_o}, 32'd0);
        chk("post-rst no valid", {31'd0, bus0.valid_o}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 6)       c = (r < 3) ? 8'h52 : 8'h57;
            else if (r < 70) c = hx[$urandom_range(0, 21)];
            else if (r < 80) c = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            else             c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(c, ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);
        end

        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("q0 drained", exp_q0.size(), 32'd0);
        chk("q1 drained", exp_q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
